bcd2bin_seq: RTL and testbench
==============================

# bcd2bin_seq

Multi-cycle, parametrised BCD-to-binary converter. It accepts a packed vector of DIGITS BCD digits over a valid/ready handshake and iteratively converts it with a reverse double-dabble shifter, one bit per clock. The result is presented over a second valid/ready handshake. It replaces the single-cycle 4-digit combinational converter on the keypad/display input path, where digit count must scale and the combinational depth no longer meets timing.

## Interface
- DIGITS, 4, number of BCD digits in the input; must be ≥1.
- BIN_W, 14, binary result width; must be ≥ ceil(log2(10^DIGITS)), e.g. 14 for 4 digits, 20 for 6.
- clk  input  1  sole clock; all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  bcd_in holds a digit vector to convert.
- in_ready  output  1  block can accept an input this cycle.
- bcd_in  input  4*DIGITS  packed digits; [3:0] is the ones digit, [4*DIGITS-1:4*DIGITS-4] is the most significant.
- out_valid  output  1  bin_out and err are valid.
- out_ready  input  1  downstream accepts the result this cycle.
- bin_out  output  BIN_W  converted value.
- err  output  1  an input digit was >9 (only with BCD2BIN_CHECK_EN).

## Operation
- Internal shifter width is 4*DIGITS+BIN_W. The low BIN_W bits hold the result; the upper field holds the digits, ones digit lowest.
- An iteration counter of width clog2(BIN_W+1) counts the shifts.
- FSM states are IDLE, SHIFT and DONE.
  - IDLE: in_ready=1. On in_valid, load the shifter with {bcd_in, BIN_W'b0}, clear the counter and go to SHIFT.
  - SHIFT: each cycle, shift the whole shifter right by 1. Then, for every digit field, if the field is ≥8, subtract 3. Both steps form one registered update. Increment the counter. After the BIN_W-th shift, go to DONE.
  - DONE: out_valid=1, with bin_out equal to shifter[BIN_W-1:0]. Hold bin_out and err stable while out_ready=0. On out_ready, go to IDLE.
- in_ready is 0 in SHIFT and DONE. Inputs presented then are ignored, not queued.
- Arithmetic is unsigned. Correction uses 4-bit subtraction per digit field with no inter-digit borrow.
- Input digits >9 without the check feature give an undefined but deterministic bin_out. The block must not hang.

## Timing
- Reset values: in_ready=0 during reset and 1 in the first cycle after reset release. out_valid=0, bin_out=0, err=0. FSM is IDLE, shifter and counter are 0.
- Latency: if input is accepted at edge E, out_valid rises after edge E+BIN_W. For the default parameters that is 14 cycles after acceptance.
- The result transfers on the edge where out_valid and out_ready are both 1. The FSM is in IDLE on the following cycle, so in_ready=1 one cycle after the output transfer.
- Throughput is at most one conversion per BIN_W+2 cycles.
- Reset mid-operation (SHIFT or DONE): at the next edge with rst_n=0, everything returns to reset values. The pending result is discarded and out_valid never rises for it.
- A bcd_in change during SHIFT has no effect on the result in progress.

## Configuration
- BCD2BIN_CHECK_EN defined:
  - At acceptance, a flag is registered if any digit of bcd_in is >9.
  - In DONE, err=1 and bin_out is forced to 0 when the flag is set.
  - Latency and handshake are unchanged.
- Not defined: err is tied to 0, and no comparison logic is synthesised.

## Test plan
- Defaults, bcd_in=16'h9999, out_ready=1 -> out_valid rises 14 cycles after acceptance with bin_out=14'd9999 and err=0.
- bcd_in=16'h1234, then 16'h0000 back to back -> bin_out=1234, then bin_out=0. in_ready is low between acceptance and output transfer.
- Back-pressure: out_ready=0 for 20 cycles after out_valid on input 16'h0507 -> bin_out=507 held stable, in_ready stays 0. Release out_ready -> one transfer, in_ready=1 on the next cycle.
- Reset: rst_n=0 for one cycle at shift 7 of 16'h4321 -> all outputs return to reset values, no out_valid follows, and a fresh 16'h0042 converts to 42.
- With BCD2BIN_CHECK_EN, bcd_in=16'h12A4 -> err=1 and bin_out=0 at standard latency. Without the macro, err=0.
- DIGITS=6, BIN_W=20, bcd_in=24'h999999 -> bin_out=20'd999999 after 20 cycles.

Source files
------------

// File: rtl/bcd2bin_seq_if.sv
// Handshake bundle for bcd2bin_seq: digit vector in (valid/ready) and binary result out (valid/ready).
// The converter takes the slave side; the producer/consumer takes the master side.
interface bcd2bin_seq_if #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [BIN_W-1:0]      bin_out;
    logic                  err;

    modport slave (
        input  in_valid, bcd_in, out_ready,
        output in_ready, out_valid, bin_out, err
    );

    modport master (
        output in_valid, bcd_in, out_ready,
        input  in_ready, out_valid, bin_out, err
    );
endinterface

// File: rtl/bcd2bin_seq.sv
// Iterative BCD-to-binary converter (reverse double dabble, one bit per clock).
// Optional macro BCD2BIN_CHECK_EN: flag digits >9, then report err=1 with bin_out forced to 0.
module bcd2bin_seq #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic          clk,
    input  logic          rst_n,
    bcd2bin_seq_if.slave  bus
);
    localparam int SH_W  = 4*DIGITS + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // One iteration: shift right, then pull every digit field >=8 back by 3 (no inter-digit borrow).
    function automatic logic [SH_W-1:0] dabble_step(input logic [SH_W-1:0] sh);
        logic [SH_W-1:0] t;
        t = sh >> 1;
        for (int k = 0; k < DIGITS; k++) begin
            t[BIN_W+4*k +: 4] = (t[BIN_W+4*k +: 4] >= 4'd8) ? (t[BIN_W+4*k +: 4] - 4'd3)
                                                            : t[BIN_W+4*k +: 4];
        end
        return t;
    endfunction

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [SH_W-1:0]    r_shreg;
    logic [SH_W-1:0]    w_shreg_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [BIN_W-1:0]   r_bin_out;
    logic [BIN_W-1:0]   w_result;
    logic               w_accept;
    logic               w_finish;

    assign w_accept = r_in_ready & bus.in_valid;
    assign w_finish = (r_state == S_SHIFT) && (w_state_nxt == S_DONE);

    // Next-state, shifter and counter update.
    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_SHIFT;
                    w_shreg_nxt = {bus.bcd_in, {BIN_W{1'b0}}};
                    w_cnt_nxt   = {CNT_W{1'b0}};
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SHIFT: begin
                w_shreg_nxt = dabble_step(r_shreg);
                w_cnt_nxt   = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                if (r_cnt == CNT_W'(BIN_W - 1)) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_SHIFT;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

`ifdef BCD2BIN_CHECK_EN
    logic r_flag;
    logic r_err;

    function automatic logic has_bad_digit(input logic [4*DIGITS-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            bad = bad | (v[4*k +: 4] > 4'd9);
        end
        return bad;
    endfunction

    assign w_result = r_flag ? {BIN_W{1'b0}} : w_shreg_nxt[BIN_W-1:0];
    assign bus.err  = r_err;

    // Invalid-digit flag captured at acceptance and exposed alongside the result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_flag <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_flag <= w_accept ? has_bad_digit(bus.bcd_in) : r_flag;
            r_err  <= w_finish ? r_flag : r_err;
        end
    end
`else
    assign w_result = w_shreg_nxt[BIN_W-1:0];
    assign bus.err  = 1'b0;
`endif

    // Main state and registered handshake outputs; the result register only loads on completion.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_shreg     <= {SH_W{1'b0}};
            r_cnt       <= {CNT_W{1'b0}};
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_bin_out   <= {BIN_W{1'b0}};
        end else begin
            r_state     <= w_state_nxt;
            r_shreg     <= w_shreg_nxt;
            r_cnt       <= w_cnt_nxt;
            r_in_ready  <= (w_state_nxt == S_IDLE);
            r_out_valid <= (w_state_nxt == S_DONE);
            r_bin_out   <= w_finish ? w_result : r_bin_out;
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.bin_out   = r_bin_out;
endmodule

// File: tb/tb_bcd2bin_seq.sv
// Self-checking bench for bcd2bin_seq: 4-digit and 6-digit instances against a decimal-arithmetic model.
module tb_bcd2bin_seq;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    bcd2bin_seq_if #(.DIGITS(4), .BIN_W(14)) b4 ();
    bcd2bin_seq_if #(.DIGITS(6), .BIN_W(20)) b6 ();

    bcd2bin_seq #(.DIGITS(4), .BIN_W(14)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
    bcd2bin_seq #(.DIGITS(6), .BIN_W(20)) u_dut6 (.clk(clk), .rst_n(rst_n), .bus(b6));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: decimal value of a packed digit vector, ones digit lowest.
    function automatic int bcd_val(input logic [23:0] v, input int nd);
        int s;
        int p;
        s = 0;
        p = 1;
        for (int k = 0; k < nd; k++) begin
            s = s + int'(v[4*k +: 4]) * p;
            p = p * 10;
        end
        return s;
    endfunction

    function automatic logic [23:0] rand_bcd(input int nd);
        logic [23:0] v;
        v = 24'h0;
        for (int k = 0; k < nd; k++) v[4*k +: 4] = 4'($urandom_range(0, 9));
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer v when ready; return the cycles from acceptance edge until out_valid (bounded).
    task automatic send4(input logic [15:0] v, output int n, output int rdy_seen);
        int w;
        w = 0;
        while (!b4.in_ready && w < 50) begin tick(); w++; end
        b4.bcd_in   = v;
        b4.in_valid = 1'b1;
        tick();
        b4.in_valid = 1'b0;
        n = 0;
        rdy_seen = 0;
        while (!b4.out_valid && n < 100) begin
            if (b4.in_ready) rdy_seen++;
            b4.bcd_in = 16'($urandom);
            tick();
            n++;
        end
    endtask

    task automatic send6(input logic [23:0] v, output int n);
        int w;
        w = 0;
        while (!b6.in_ready && w < 50) begin tick(); w++; end
        b6.bcd_in   = v;
        b6.in_valid = 1'b1;
        tick();
        b6.in_valid = 1'b0;
        n = 0;
        while (!b6.out_valid && n < 100) begin tick(); n++; end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        b4.in_valid = 1'b0; b4.out_ready = 1'b0; b4.bcd_in = 16'h0;
        b6.in_valid = 1'b0; b6.out_ready = 1'b0; b6.bcd_in = 24'h0;
        tick(); tick();
        checks++;
        if ({b4.in_ready, b4.out_valid, b4.err} !== 3'b000 || b4.bin_out !== 14'd0) begin
            errors++;
            $display("FAIL reset_state: rdy/vld/err=%b bin=%0d, want 000 bin=0",
                     {b4.in_ready, b4.out_valid, b4.err}, b4.bin_out);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (b4.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b want 1", b4.in_ready);
        end
    endtask

    task automatic test_max();
        int n, r;
        b4.out_ready = 1'b1;
        send4(16'h9999, n, r);
        checks++;
        if (n !== 14) begin errors++; $display("FAIL max_latency: got %0d want 14", n); end
        checks++;
        if (b4.bin_out !== 14'd9999 || b4.err !== 1'b0) begin
            errors++; $display("FAIL max_value: got %0d err=%b want 9999 err=0", b4.bin_out, b4.err);
        end
        tick();
        checks++;
        if (b4.out_valid !== 1'b0 || b4.in_ready !== 1'b1) begin
            errors++; $display("FAIL max_transfer: vld=%b rdy=%b want 0 1", b4.out_valid, b4.in_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] vals [2];
        int n, r;
        vals[0] = 16'h1234;
        vals[1] = 16'h0000;
        b4.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            send4(vals[i], n, r);
            checks++;
            if (n !== 14 || r !== 0) begin
                errors++; $display("FAIL b2b_timing[%0d]: lat=%0d ready_cycles=%0d want 14 0", i, n, r);
            end
            checks++;
            if (int'(b4.bin_out) !== bcd_val(24'(vals[i]), 4)) begin
                errors++; $display("FAIL b2b_value[%0d]: got %0d want %0d", i, b4.bin_out, bcd_val(24'(vals[i]), 4));
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int n, r;
        b4.out_ready = 1'b0;
        send4(16'h0507, n, r);
        checks++;
        if (n !== 14) begin errors++; $display("FAIL bp_latency: got %0d want 14", n); end
        for (int i = 0; i < 20; i++) begin
            b4.in_valid = 1'b1;
            b4.bcd_in   = 16'h8888;
            tick();
            checks++;
            if (b4.out_valid !== 1'b1 || b4.in_ready !== 1'b0 || b4.bin_out !== 14'd507) begin
                errors++;
                $display("FAIL bp_hold[%0d]: vld=%b rdy=%b bin=%0d want 1 0 507", i, b4.out_valid, b4.in_ready, b4.bin_out);
            end
        end
        b4.in_valid  = 1'b0;
        b4.out_ready = 1'b1;
        tick();
        checks++;
        if (b4.out_valid !== 1'b0 || b4.in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release: vld=%b rdy=%b want 0 1", b4.out_valid, b4.in_ready);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        int n, r;
        b4.out_ready = 1'b1;
        b4.bcd_in    = 16'h4321;
        b4.in_valid  = 1'b1;
        tick();
        b4.in_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        rst_n = 1'b0;
        tick();
        checks++;
        if ({b4.in_ready, b4.out_valid, b4.err} !== 3'b000 || b4.bin_out !== 14'd0) begin
            errors++;
            $display("FAIL mid_reset_state: rdy/vld/err=%b bin=%0d want 000 0",
                     {b4.in_ready, b4.out_valid, b4.err}, b4.bin_out);
        end
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (b4.out_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL mid_reset_no_valid: got %0d valid cycles want 0", seen); end
        send4(16'h0042, n, r);
        checks++;
        if (n !== 14 || b4.bin_out !== 14'd42) begin
            errors++; $display("FAIL mid_reset_fresh: lat=%0d bin=%0d want 14 42", n, b4.bin_out);
        end
        tick();
    endtask

    task automatic test_random();
        logic [15:0] v;
        int n, r, hold, exp;
        for (int i = 0; i < 30; i++) begin
            v = rand_bcd(4)[15:0];
            exp = bcd_val(24'(v), 4);
            b4.out_ready = 1'b0;
            send4(v, n, r);
            hold = $urandom_range(0, 3);
            for (int h = 0; h < hold; h++) tick();
            checks++;
            if (n !== 14 || b4.out_valid !== 1'b1 || int'(b4.bin_out) !== exp || b4.err !== 1'b0) begin
                errors++;
                $display("FAIL rand[%0d] in=%h: lat=%0d vld=%b bin=%0d err=%b want 14 1 %0d 0",
                         i, v, n, b4.out_valid, b4.bin_out, b4.err, exp);
            end
            b4.out_ready = 1'b1;
            tick();
        end
    endtask

    task automatic test_check();
        int n, r;
        b4.out_ready = 1'b1;
        send4(16'h12A4, n, r);
        checks++;
`ifdef BCD2BIN_CHECK_EN
        if (n !== 14 || b4.err !== 1'b1 || b4.bin_out !== 14'd0) begin
            errors++; $display("FAIL check_bad_digit: lat=%0d err=%b bin=%0d want 14 1 0", n, b4.err, b4.bin_out);
        end
`else
        if (n !== 14 || b4.err !== 1'b0) begin
            errors++; $display("FAIL check_disabled: lat=%0d err=%b want 14 0", n, b4.err);
        end
`endif
        tick();
        send4(16'h0815, n, r);
        checks++;
        if (b4.err !== 1'b0 || b4.bin_out !== 14'd815) begin
            errors++; $display("FAIL check_clear: err=%b bin=%0d want 0 815", b4.err, b4.bin_out);
        end
        tick();
    endtask

    task automatic test_wide();
        logic [23:0] vals [3];
        int n;
        vals[0] = 24'h999999;
        vals[1] = rand_bcd(6);
        vals[2] = 24'h000001;
        b6.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send6(vals[i], n);
            checks++;
            if (n !== 20 || int'(b6.bin_out) !== bcd_val(vals[i], 6)) begin
                errors++;
                $display("FAIL wide[%0d] in=%h: lat=%0d bin=%0d want 20 %0d", i, vals[i], n, b6.bin_out, bcd_val(vals[i], 6));
            end
            tick();
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_max();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_check();
        test_wide();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
